// File: rtl/wavetable_reader.sv
`default_nettype none
// ============================================================================
//  Module      : wavetable_reader
//  Description : Phase-accumulator oscillator reading a 256x16 packed sine
//                ROM (two 8-bit offset-binary samples per word). Converts the
//                selected byte to signed, left-justified audio and presents it
//                on a valid/ready stream. The last fetched ROM word is cached
//                so that consecutive samples from the same word skip the read.
//  Revision    : 1.0  initial release
// ============================================================================
module wavetable_reader #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               sync_clr,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic               rom_en,
    output logic [7:0]         rom_addr,
    input  logic [15:0]        rom_dout,
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid,
    input  logic               sample_ready
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOOKUP  = 3'd1;
    localparam logic [2:0] c_FETCH   = 3'd2;
    localparam logic [2:0] c_CAPTURE = 3'd3;
    localparam logic [2:0] c_PRESENT = 3'd4;

    logic [2:0]         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic               r_cache_valid;
    logic [7:0]         r_cache_addr;
    logic [15:0]        r_cache_word;
    logic               r_stale;       // a clear arrived while the ROM read was in flight
    logic [7:0]         r_rom_addr;
    logic [OUT_W-1:0]   r_sample;
    logic               r_valid;

    logic [7:0]         w_word_idx;
    logic               w_odd;
    logic               w_hit;
    logic               w_handshake;
    logic [7:0]         w_cache_byte;
    logic [7:0]         w_rom_byte;
    logic [OUT_W-1:0]   w_cache_sample;
    logic [OUT_W-1:0]   w_rom_sample;

    assign w_word_idx   = r_phase[PHASE_W-1 -: 8];
    assign w_odd        = r_phase[PHASE_W-9];
    assign w_hit        = r_cache_valid && (r_cache_addr == w_word_idx);
    assign w_handshake  = r_valid && sample_ready;

    // Even sample index lives in the low byte, odd index in the high byte.
    assign w_cache_byte = w_odd ? r_cache_word[15:8] : r_cache_word[7:0];
    assign w_rom_byte   = w_odd ? rom_dout[15:8]     : rom_dout[7:0];

    // Offset-binary to two's complement is an MSB flip; pad to the output width.
    generate
        if (OUT_W > 8) begin : g_pad
            assign w_cache_sample = {~w_cache_byte[7], w_cache_byte[6:0], {(OUT_W-8){1'b0}}};
            assign w_rom_sample   = {~w_rom_byte[7],   w_rom_byte[6:0],   {(OUT_W-8){1'b0}}};
        end else begin : g_nopad
            assign w_cache_sample = {~w_cache_byte[7], w_cache_byte[6:0]};
            assign w_rom_sample   = {~w_rom_byte[7],   w_rom_byte[6:0]};
        end
    endgenerate

    // Oscillator FSM, phase accumulator, word cache and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_phase       <= '0;
            r_cache_valid <= 1'b0;
            r_cache_addr  <= 8'd0;
            r_cache_word  <= 16'd0;
            r_stale       <= 1'b0;
            r_rom_addr    <= 8'd0;
            r_sample      <= '0;
            r_valid       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (enable) begin
                        r_state <= c_LOOKUP;
                    end
                end
                c_LOOKUP: begin
                    if (w_hit) begin
                        r_sample <= w_cache_sample;
                        r_valid  <= 1'b1;
                        r_state  <= c_PRESENT;
                    end else begin
                        r_rom_addr <= w_word_idx;
                        r_state    <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    r_state <= c_CAPTURE;
                end
                c_CAPTURE: begin
                    r_cache_word <= rom_dout;
                    r_cache_addr <= r_rom_addr;
                    r_stale      <= 1'b0;
                    if (r_stale) begin
                        // Word belongs to a phase that was cleared; do not trust it.
                        r_state <= enable ? c_LOOKUP : c_IDLE;
                    end else begin
                        r_cache_valid <= 1'b1;
                        if (enable) begin
                            r_sample <= w_rom_sample;
                            r_valid  <= 1'b1;
                            r_state  <= c_PRESENT;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_PRESENT: begin
                    if (w_handshake) begin
                        r_phase <= r_phase + phase_inc;
                        r_valid <= 1'b0;
                        r_state <= enable ? c_LOOKUP : c_IDLE;
                    end else if (!enable) begin
                        // Withdraw the sample unconsumed; it is re-fetched on restart.
                        r_valid <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Clear overrides everything above, including a same-cycle handshake.
            if (sync_clr) begin
                r_phase       <= '0;
                r_cache_valid <= 1'b0;
                r_valid       <= 1'b0;
                if (r_state == c_FETCH) begin
                    r_stale <= 1'b1;
                end else begin
                    r_state <= enable ? c_LOOKUP : c_IDLE;
                end
            end
        end
    end

    assign rom_en       = (r_state == c_FETCH);
    assign rom_addr     = r_rom_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wavetable_reader
//  Description : Self-checking bench for wavetable_reader. A registered ROM
//                model holds a 512-point sine table; a monitor keeps the
//                oscillator phase and scoreboards every accepted sample.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wavetable_reader;

    localparam int  PHASE_W = 24;
    localparam int  OUT_W   = 16;
    localparam real PI      = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               sync_clr = 1'b0;
    logic [PHASE_W-1:0] phase_inc = '0;
    logic               rom_en;
    logic [7:0]         rom_addr;
    logic [15:0]        rom_dout = 16'd0;
    logic [OUT_W-1:0]   sample_out;
    logic               sample_valid;
    logic               sample_ready = 1'b0;

    always #5 clk = ~clk;

    wavetable_reader #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sync_clr     (sync_clr),
        .phase_inc    (phase_inc),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    // 512-point offset-binary sine, index 0 = 0x7F
    logic [7:0] sine [512];
    initial begin
        for (int i = 0; i < 512; i++)
            sine[i] = 8'($rtoi(127.0 + 127.0 * $sin(2.0 * PI * i / 512.0) + 1.0e-9));
    end

    // Registered ROM: two samples per word, even index in the low byte
    always @(posedge clk) begin
        if (rom_en)
            rom_dout <= {sine[2 * int'(rom_addr) + 1], sine[2 * int'(rom_addr)]};
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Expected audio word for a phase: sample index is the top 9 bits,
    // signed value is byte-128 scaled by 256.
    function automatic logic [15:0] expect_at(input logic [PHASE_W-1:0] ph);
        int idx;
        int v;
        idx = int'(ph >> (PHASE_W - 9));
        v   = (int'(sine[idx]) - 128) * 256;
        return v[15:0];
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [15:0]        exp_q [$];
    logic [PHASE_W-1:0] m_phase = '0;
    int                 hs_count = 0;
    int                 hs_cyc [$];
    logic [15:0]        hs_val [$];
    int                 rom_pulses = 0;
    logic [7:0]         last_fetch_addr = 8'd0;
    bit                 prev_hold = 0;
    logic [15:0]        prev_sample = 16'd0;

    always @(negedge clk) begin
        bit hs;
        logic [15:0] e;
        if (!rst_n) begin
            m_phase = '0;
            exp_q.delete();
            exp_q.push_back(expect_at('0));
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(sample_valid), 32'd1);
                check("hold_data", 32'(sample_out), 32'(prev_sample));
            end
            if (rom_en) begin
                rom_pulses++;
                check("fetch_addr", 32'(rom_addr), 32'(m_phase[PHASE_W-1 -: 8]));
                last_fetch_addr = rom_addr;
            end
            hs = sample_valid && sample_ready;
            if (hs) begin
                hs_count++;
                hs_cyc.push_back(cyc);
                hs_val.push_back(sample_out);
                if (exp_q.size() == 0) begin
                    fail_now("scoreboard_empty");
                end else begin
                    e = exp_q.pop_front();
                    check("sample", 32'(sample_out), 32'(e));
                end
            end
            if (sync_clr) begin
                m_phase = '0;
                exp_q.delete();
                exp_q.push_back(expect_at(m_phase));
            end else if (hs) begin
                m_phase = m_phase + phase_inc;
                exp_q.push_back(expect_at(m_phase));
            end
            prev_hold   = sample_valid && !sample_ready && enable && !sync_clr;
            prev_sample = sample_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_valid(input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 0;
        while (n < max_cyc) begin
            @(posedge clk); #1;
            n++;
            if (sample_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("wait_valid");
    endtask

    task automatic accept_one(input logic [PHASE_W-1:0] inc, output logic [15:0] v);
        int n;
        bit ok;
        v = 16'hxxxx;
        wait_valid(20, n, ok);
        if (ok) begin
            v            = sample_out;
            phase_inc    = inc;
            sample_ready = 1'b1;
            @(posedge clk); #1;
            sample_ready = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int          n;
        bit          ok;
        int          b;
        int          p;
        int          bad;
        logic [15:0] v;
        logic [15:0] s;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_rom_en", 32'(rom_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold start, free-running with ready held high
        phase_inc    = 24'h008000;
        sample_ready = 1'b1;
        b            = hs_count;
        enable       = 1'b1;
        wait_valid(10, n, ok);
        check("first_latency", 32'(n), 32'd4);
        n = 0;
        while (hs_count < b + 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        sample_ready = 1'b0;
        if (hs_count < b + 3) begin
            fail_now("first_three");
        end else begin
            check("s0_idx0", 32'(hs_val[b]),     32'h0000FF00);
            check("s1_idx1", 32'(hs_val[b + 1]), 32'h00000000);
            check("s2_idx2", 32'(hs_val[b + 2]), 32'h00000200);
            check("hit_gap", 32'(hs_cyc[b + 1] - hs_cyc[b]), 32'd2);
            check("miss_gap", 32'(hs_cyc[b + 2] - hs_cyc[b + 1]), 32'd4);
            check("fetches_2", 32'(rom_pulses), 32'd2);
            check("fetch_addr1", 32'(last_fetch_addr), 32'd1);
        end

        // Peak, trough and wrap after a clear
        pulse_clr();
        accept_one(24'h400000, v); check("clr_idx0", 32'(v), 32'h0000FF00);
        accept_one(24'h800000, v); check("peak_128", 32'(v), 32'h00007E00);
        accept_one(24'h3F8000, v); check("trough_384", 32'(v), 32'h00008000);
        accept_one(24'h008000, v); check("idx_511", 32'(v), 32'h0000FD00);
        p = rom_pulses;
        accept_one(24'h008000, v); check("wrap_idx0", 32'(v), 32'h0000FF00);
        check("wrap_fetches", 32'(rom_pulses - p), 32'd1);
        check("wrap_addr", 32'(last_fetch_addr), 32'd0);

        // Backpressure: presented sample holds, no fetch, phase frozen
        wait_valid(20, n, ok);
        s = sample_out;
        p = rom_pulses;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(sample_valid), 32'd1);
            check("bp_data", 32'(sample_out), 32'(s));
        end
        check("bp_no_fetch", 32'(rom_pulses - p), 32'd0);
        accept_one(24'h008000, v); check("bp_idx1", 32'(v), 32'h00000000);

        // Zero increment: one fetch serves 50 samples
        wait_valid(20, n, ok);
        pulse_clr();
        p            = rom_pulses;
        b            = hs_count;
        phase_inc    = '0;
        sample_ready = 1'b1;
        n            = 0;
        while (hs_count < b + 50 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        sample_ready = 1'b0;
        check("zero_inc_count", 32'(hs_count - b), 32'd50);
        check("zero_inc_fetches", 32'(rom_pulses - p), 32'd1);
        bad = 0;
        for (int i = b; i < hs_count; i++) if (hs_val[i] !== 16'hFF00) bad++;
        check("zero_inc_values", 32'(bad), 32'd0);

        // Clear coincident with handshake
        accept_one(24'h5A0000, v); check("pre_clr_idx0", 32'(v), 32'h0000FF00);
        wait_valid(20, n, ok);
        b            = hs_count;
        phase_inc    = 24'h008000;
        sync_clr     = 1'b1;
        sample_ready = 1'b1;
        @(posedge clk); #1;
        sync_clr     = 1'b0;
        sample_ready = 1'b0;
        check("clr_hs_consumed", 32'(hs_count - b), 32'd1);
        check("clr_hs_valid_low", 32'(sample_valid), 32'd0);
        accept_one(24'h008000, v); check("clr_hs_restart", 32'(v), 32'h0000FF00);

        // Reset while the ROM word is being captured
        pulse_clr();
        n = 0;
        while (!rom_en && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rom_en) fail_now("wait_fetch");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstcap_valid", 32'(sample_valid), 32'd0);
        check("rstcap_rom_en", 32'(rom_en), 32'd0);
        check("rstcap_rom_addr", 32'(rom_addr), 32'd0);
        check("rstcap_sample", 32'(sample_out), 32'd0);
        rst_n = 1'b1;
        wait_valid(10, n, ok);
        check("post_rst_latency", 32'(n), 32'd4);
        accept_one(24'h000000, v); check("post_rst_idx0", 32'(v), 32'h0000FF00);

        // Randomized traffic
        b = hs_count;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            enable       = ($urandom_range(0, 15) != 0);
            sample_ready = ($urandom_range(0, 9) < 6);
            sync_clr     = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0:       phase_inc = '0;
                1:       phase_inc = 24'($urandom_range(1, 3)) << 15;
                2:       phase_inc = 24'($urandom_range(0, 255)) << 16;
                default: phase_inc = 24'($urandom);
            endcase
        end
        @(posedge clk); #1;
        enable       = 1'b0;
        sample_ready = 1'b0;
        sync_clr     = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("random_progress", 32'(hs_count - b >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
